// File: rtl/btn_cond2.sv
// btn_cond2: two-channel button conditioner.
// Each channel: 2-flop sync, 4-state debounce FSM, rise pulse.
module btn_cond2 #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw0,
  input  logic sw1,
  output logic x0,
  output logic x1,
  output logic x0_rise,
  output logic x1_rise
);

  localparam int unsigned CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  logic [1:0] sw;
  logic [1:0] x;
  logic [1:0] rise;

  assign sw      = {sw1, sw0};
  assign x0      = x[0];
  assign x1      = x[1];
  assign x0_rise = rise[0];
  assign x1_rise = rise[1];

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          s1;
    logic          s2;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          x_q;
    logic          x_nx;
    logic          rise_q;
    logic          rise_nx;

    // Synchronizer, FSM state, counter and registered outputs.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        state  <= LOW;
        cnt    <= '0;
        x_q    <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        s1     <= sw[i];
        s2     <= s1;
        state  <= state_nx;
        cnt    <= cnt_nx;
        x_q    <= x_nx;
        rise_q <= rise_nx;
      end
    end

    // Next state, counter and output decode from the synced level.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
        LOW: begin
          if (s2) begin
            state_nx = WAIT_HIGH;
            cnt_nx   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            state_nx = LOW;
            cnt_nx   = '0;
          end else if (cnt == CMAX) begin
            state_nx = HIGH;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!s2) begin
            state_nx = WAIT_LOW;
            cnt_nx   = '0;
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state_nx = HIGH;
            cnt_nx   = '0;
          end else if (cnt == CMAX) begin
            state_nx = LOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = LOW;
          cnt_nx   = '0;
        end
      endcase
      x_nx    = (state_nx == HIGH) || (state_nx == WAIT_LOW);
      rise_nx = (state == WAIT_HIGH) && (state_nx == HIGH);
    end

    assign x[i]    = x_q;
    assign rise[i] = rise_q;
  end

endmodule
